// File: rtl/mux_arbiter_if.sv
// Bus bundle between the three byte sources, the round-robin arbiter and the
// downstream consumer. The arbiter sits on the slave side; the sources and
// consumer (or a bench) drive the master side.
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       req;
    logic [WIDTH-1:0] alpha;
    logic [WIDTH-1:0] beta;
    logic [WIDTH-1:0] gamma;
    logic [2:0]       gnt;
    logic [1:0]       sel;
    logic             cs;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport slave (
        input  req, alpha, beta, gamma,
        output gnt, sel, cs, out, out_valid
    );

    modport master (
        output req, alpha, beta, gamma,
        input  gnt, sel, cs, out, out_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin owner of the shared 3:1 byte mux. Decides which source holds
// the mux and for how many cycles (up to BURST), drives registered sel/cs/gnt
// and registers the selected byte one cycle behind the select.
module mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    mux_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             cs_q, cs_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic [1:0]       winner;
    logic             any_req;
    logic             grant_end;

    // Scan requests starting just after the pointer; the pointer's own
    // source is checked last so it only wins when nobody else is asking.
    always_comb begin
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
        case (last_q)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        any_req = |bus.req;
        if (bus.req[first])
            winner = first;
        else if (bus.req[second])
            winner = second;
        else
            winner = third;
    end

    // Next owner / pointer / burst counter.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant_end = !bus.req[cur_q] || (cnt_q == BURST_L);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    cur_d   = winner;
                    last_d  = winner;
                    cnt_d   = 4'd1;
                end
            end
            default: begin
                if (!grant_end) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (any_req) begin
                    cur_d  = winner;
                    last_d = winner;
                    cnt_d  = 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
        endcase
    end

    // One-hot grant decoded from the next owner so gnt lands with sel/cs.
    for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
        assign gnt_d[gi] = (state_d == GRANT) && (cur_d == 2'(gi));
    end

    // Mux controls and the registered data path (data follows sel by a cycle).
    always_comb begin
        sel_d       = (state_d == GRANT) ? cur_d : 2'd0;
        cs_d        = (state_d == GRANT);
        out_valid_d = cs_q;
        out_d       = '0;
        if (cs_q) begin
            case (sel_q)
                2'd0:    out_d = bus.alpha;
                2'd1:    out_d = bus.beta;
                2'd2:    out_d = bus.gamma;
                default: out_d = '0;
            endcase
        end
    end

    // FSM state, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= 2'd0;
            last_q      <= 2'd2;
            cnt_q       <= 4'd0;
            gnt_q       <= 3'b000;
            sel_q       <= 2'd0;
            cs_q        <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            cs_q        <= cs_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.cs        = cs_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule
